// File: rtl/rr_grant_index.sv
// rr_grant_index: round-robin arbiter over NUM_REQ level requests.
// The winner is presented as a registered binary index with a valid/ready
// handshake. The grant is held until accepted, after which the priority
// pointer moves to the slot just past the winner.
//
// Optional feature macro: RR_BACK2BACK_EN
//   defined   - on acceptance, re-arbitrate in the same edge (1 grant/cycle)
//   undefined - acceptance always returns to IDLE (1 grant per 2 cycles)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant presented; arbitrate as soon as any request is high
// GRANT | gnt_idx presented with valid high, held until gnt_ready_i
module rr_grant_index #(
  parameter int unsigned NUM_REQ = 16,
  parameter int unsigned IDX_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               gnt_ready_i,
  output logic               gnt_valid_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;

  logic             handshake;
  logic [IDX_W-1:0] ptr_inc;
  logic [IDX_W-1:0] sel_base;
  logic [IDX_W-1:0] sel_idx;

  // First set request scanning circularly from base; base itself when none is
  // set (callers only use the result when at least one request is high).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   base);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] pos;
    logic             found;
    pick  = base;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = IDX_W'((32'(base) + k) % NUM_REQ);
      if (!found && req[pos]) begin
        pick  = pos;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Handshake and the post-acceptance pointer value. In GRANT the scan base is
  // the slot after the current winner, so a back-to-back re-arbitration already
  // sees the rotated priority.
  always_comb begin
    handshake = (state_q == GRANT) && gnt_ready_i;
    ptr_inc   = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
    sel_base  = (state_q == GRANT) ? ptr_inc : ptr_q;
    sel_idx   = rr_pick(req_i, sel_base);
  end

  // Next-state, pointer and grant index.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_idx_d = sel_idx;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (handshake) begin
          ptr_d = ptr_inc;
`ifdef RR_BACK2BACK_EN
          if (|req_i) begin
            gnt_idx_d = sel_idx;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any grant in flight without replay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  // Outputs come straight from flops; the index keeps its last value in IDLE.
  assign gnt_valid_o = (state_q == GRANT);
  assign gnt_idx_o   = gnt_idx_q;

endmodule

// File: tb/tb_rr_grant_index.sv
module tb_rr_grant_index;
  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] req;
  logic         rdy;
  logic         vld;
  logic [W-1:0] idx;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_ptr;
  int m_idx;
  bit m_vld;

  int grants_q[$];

  rr_grant_index #(.NUM_REQ(N), .IDX_W(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (req),
    .gnt_ready_i (rdy),
    .gnt_valid_o (vld),
    .gnt_idx_o   (idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Circular scan starting at p: the requester nearest at or after p.
  function automatic int ref_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j[W-1:0]]) return j;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_idx = 0;
    m_vld = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic rd);
    if (!m_vld) begin
      if (r != 0) begin
        m_idx = ref_pick(r, m_ptr);
        m_vld = 1;
      end
    end else if (rd) begin
      m_ptr = (m_idx + 1) % N;
`ifdef RR_BACK2BACK_EN
      if (r != 0) m_idx = ref_pick(r, m_ptr);
      else m_vld = 0;
`else
      m_vld = 0;
`endif
    end
  endtask

  // Called at a falling edge: drive inputs, clock once, compare at next falling edge.
  task automatic cyc(input logic [N-1:0] r, input logic rd, input string tag);
    req = r;
    rdy = rd;
    @(posedge clk);
    model_edge(r, rd);
    @(negedge clk);
    chk({tag, "_vld"}, {31'd0, vld}, {31'd0, m_vld});
    chk({tag, "_idx"}, {28'd0, idx}, m_idx);
  endtask

  // Advance until a grant is presented (at most one bubble exists).
  task automatic next_grant(input logic [N-1:0] r, input string tag);
    cyc(r, 1'b1, tag);
    if (!vld) cyc(r, 1'b1, tag);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req = '0;
    rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n_cyc;
    reset_n = 1'b0;
    req = '0;
    rdy = 1'b0;
    model_reset();

    // reset holds outputs low even with every request and ready high
    #1;
    req = 16'hFFFF;
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_vld", {31'd0, vld}, 32'd0);
      chk("rst_idx", {28'd0, idx}, 32'd0);
    end
    reset_n = 1'b1;
    cyc(16'hFFFF, 1'b1, "rel");
    chk("rel_first_idx", {28'd0, idx}, 32'd0);
    chk("rel_first_vld", {31'd0, vld}, 32'd1);

    // single request then rotation through the wrap
    apply_reset();
    cyc(16'h0200, 1'b1, "single");
    chk("single_idx9", {28'd0, idx}, 32'd9);
    next_grant(16'h0201, "wrap");
    chk("wrap_idx0", {28'd0, idx}, 32'd0);

    // backpressure: grant held while requests vanish
    apply_reset();
    cyc(16'h0008, 1'b0, "bp_grant");
    for (int i = 0; i < 5; i++) begin
      cyc(16'h0000, 1'b0, "bp_hold");
      chk("bp_hold_idx3", {28'd0, idx}, 32'd3);
      chk("bp_hold_vld1", {31'd0, vld}, 32'd1);
    end
    cyc(16'h0000, 1'b1, "bp_accept");
    chk("bp_accept_idle", {31'd0, vld}, 32'd0);
    cyc(16'hFFFF, 1'b0, "bp_ptr4");
    chk("bp_ptr4_idx", {28'd0, idx}, 32'd4);

    // fairness: every request high, count grants accepted in a fixed window
    apply_reset();
    cyc(16'hFFFF, 1'b1, "fair_first");
`ifdef RR_BACK2BACK_EN
    n_cyc = 16;
`else
    n_cyc = 32;
`endif
    grants_q.delete();
    for (int i = 0; i < n_cyc; i++) begin
      if (vld) grants_q.push_back(int'(idx));
      cyc(16'hFFFF, 1'b1, "fair");
    end
    chk("fair_count", grants_q.size(), 32'd16);
    for (int i = 0; i < grants_q.size(); i++) chk("fair_seq", grants_q[i], i);
    if (!vld) cyc(16'hFFFF, 1'b1, "fair_wrap");
    chk("fair_wrap_idx0", {28'd0, idx}, 32'd0);

    // pointer skip from ptr=14
    apply_reset();
    cyc(16'h2000, 1'b0, "skip_setup");
    cyc(16'h0000, 1'b1, "skip_setup_acc");
    cyc(16'h0012, 1'b1, "skip_a");
    chk("skip_idx1", {28'd0, idx}, 32'd1);
    next_grant(16'h0012, "skip_b");
    chk("skip_idx4", {28'd0, idx}, 32'd4);
    next_grant(16'h0012, "skip_c");
    chk("skip_idx1b", {28'd0, idx}, 32'd1);

    // reset mid-grant drops valid at once; re-grant starts from ptr 0
    apply_reset();
    cyc(16'h0080, 1'b0, "mid");
    chk("mid_idx7", {28'd0, idx}, 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_vld", {31'd0, vld}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cyc(16'h0080, 1'b1, "mid_regrant");
    chk("mid_regrant_idx7", {28'd0, idx}, 32'd7);

    // randomized traffic against the model
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r;
      logic         rd;
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = N'($urandom) & N'($urandom) & N'($urandom);
        2: r = N'(1) << $urandom_range(0, N - 1);
        default: r = N'($urandom);
      endcase
      rd = ($urandom_range(0, 3) != 0);
      cyc(r, rd, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
